// File: rtl/time_set_ctrl_if.sv
// Button inputs and time-counter control strobes for the clock datapath.
interface time_set_ctrl_if;
  logic       BTN_MODE;
  logic       BTN_SET;
  logic       BTN_CLR;
  logic       EN_SEC;
  logic       INC_MIN;
  logic       INC_HOUR;
  logic       CLR;
  logic [1:0] MODE;
  logic       BLINK;

  modport master (
    output BTN_MODE, BTN_SET, BTN_CLR,
    input  EN_SEC, INC_MIN, INC_HOUR, CLR, MODE, BLINK
  );

  modport slave (
    input  BTN_MODE, BTN_SET, BTN_CLR,
    output EN_SEC, INC_MIN, INC_HOUR, CLR, MODE, BLINK
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Clock-setting front end: one-second enable, button conditioning,
// RUN/SET_MIN/SET_HOUR mode FSM with SET auto-repeat.
module time_set_ctrl #(
  parameter int PRESCALE     = 50000000,
  parameter int DEB_CYCLES   = 1000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic           CLK,
  input  logic           RST,
  time_set_ctrl_if.slave io
);
  localparam int PW   = $clog2(PRESCALE);
  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_HALF = PW'(PRESCALE / 2 - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE = RW'(REPEAT_RATE);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_MIN  = 2'b01,
    SET_HOUR = 2'b10
  } mode_e;

  // button bit order: [0] mode, [1] set, [2] clear
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    deb_q, deb_d, dprev_q;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];
  logic [2:0]    press;

  assign raw   = {io.BTN_CLR, io.BTN_SET, io.BTN_MODE};
  assign press = deb_q & ~dprev_q;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == D_LAST) deb_d[i] = s2_q[i];
        else dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
    end
  end

  mode_e         mode_q, mode_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          blink_q, blink_d;
  logic          en_q, en_d;
  logic          imin_q, imin_d;
  logic          ihr_q, ihr_d;
  logic          clr_q, clr_d;
  logic          clr_p, mode_p, set_p;
  logic          tick, half, inc;

  // one press acted on per cycle: clear beats mode beats set
  assign clr_p  = press[2];
  assign mode_p = press[0] & ~press[2];
  assign set_p  = press[1] & ~press[0] & ~press[2];
  assign tick   = pcnt_q == P_LAST;
  assign half   = pcnt_q == P_HALF;

  always_comb begin
    mode_d  = mode_q;
    pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
    blink_d = blink_q ^ (tick | half);
    rep_d   = rep_q;
    clr_d   = 1'b0;
    inc     = 1'b0;
    if (clr_p) begin
      clr_d   = 1'b1;
      mode_d  = RUN;
      pcnt_d  = '0;
      blink_d = 1'b0;
      rep_d   = '0;
    end else if (mode_p) begin
      rep_d = '0;
      unique case (mode_q)
        RUN:     mode_d = SET_MIN;
        SET_MIN: mode_d = SET_HOUR;
        default: begin
          mode_d = RUN;
          pcnt_d = '0;
        end
      endcase
    end else if (set_p && mode_q != RUN) begin
      inc   = 1'b1;
      rep_d = R_DLY;
    end else if (rep_q != '0) begin
      // countdown: reaching 1 emits a repeat and rearms
      if (!deb_q[1]) begin
        rep_d = '0;
      end else if (rep_q == RW'(1)) begin
        inc   = 1'b1;
        rep_d = R_RATE;
      end else begin
        rep_d = rep_q - RW'(1);
      end
    end
    en_d   = tick && mode_q == RUN &&
             mode_d == RUN && !clr_p;
    imin_d = inc && mode_q == SET_MIN;
    ihr_d  = inc && mode_q == SET_HOUR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      dprev_q <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
      mode_q  <= RUN;
      pcnt_q  <= '0;
      rep_q   <= '0;
      blink_q <= 1'b0;
      en_q    <= 1'b0;
      imin_q  <= 1'b0;
      ihr_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      dprev_q <= deb_q;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
      mode_q  <= mode_d;
      pcnt_q  <= pcnt_d;
      rep_q   <= rep_d;
      blink_q <= blink_d;
      en_q    <= en_d;
      imin_q  <= imin_d;
      ihr_q   <= ihr_d;
      clr_q   <= clr_d;
    end
  end

  assign io.EN_SEC   = en_q;
  assign io.INC_MIN  = imin_q;
  assign io.INC_HOUR = ihr_q;
  assign io.CLR      = clr_q;
  assign io.MODE     = mode_q;
  assign io.BLINK    = blink_q;
endmodule
